// File: rtl/common.sv
// rtl/common.sv - shared operation/state types and helpers for the multiply/divide unit
package common;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } muldiv_state_t;

  typedef logic [64:0]  u65;
  typedef logic [127:0] u128;
  typedef logic [128:0] u129;

  // rs1 is interpreted as signed for these operations
  function automatic logic op_a_signed(input muldiv_op_t f);
    return (f == OP_MULH) || (f == OP_MULHSU) || (f == OP_DIV) || (f == OP_REM);
  endfunction

  // rs2 is interpreted as signed for these operations
  function automatic logic op_b_signed(input muldiv_op_t f);
    return (f == OP_MULH) || (f == OP_DIV) || (f == OP_REM);
  endfunction

endpackage

// File: rtl/div_restoring.sv
// rtl/div_restoring.sv - radix-2 restoring divider on unsigned magnitudes, one quotient bit per step
module div_restoring #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_load,
  input  logic            i_step,
  input  logic            i_word,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_quot,
  output logic [XLEN-1:0] o_rem
);

  logic [XLEN-1:0] r_quot;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_divisor;
  logic [XLEN:0]   w_shift;
  logic [XLEN:0]   w_diff;

  // Trial subtraction: a set top bit of the difference means the partial remainder was smaller
  always_comb begin
    w_shift = {r_rem, r_quot[XLEN-1]};
    w_diff  = w_shift - {1'b0, r_divisor};
  end

  // Load operands (word dividend left-aligned so 32 steps suffice), then shift one bit per step
  always_ff @(posedge clk) begin
    if (reset) begin
      r_quot    <= '0;
      r_rem     <= '0;
      r_divisor <= '0;
    end else if (i_load) begin
      r_quot    <= i_word ? (i_dividend << (XLEN - 32)) : i_dividend;
      r_rem     <= '0;
      r_divisor <= i_divisor;
    end else if (i_step) begin
      if (w_diff[XLEN]) begin
        r_rem  <= w_shift[XLEN-1:0];
        r_quot <= {r_quot[XLEN-2:0], 1'b0};
      end else begin
        r_rem  <= w_diff[XLEN-1:0];
        r_quot <= {r_quot[XLEN-2:0], 1'b1};
      end
    end
  end

  assign o_quot = r_quot;
  assign o_rem  = r_rem;

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - RV M-extension multiply/divide unit; MUL_DIV_FAST_MUL_EN selects a single-cycle multiplier
module mul_div_unit
  import common::*;
#(
  parameter int XLEN = 64,
  parameter int W_EN = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic            is_word,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;

  muldiv_state_t     r_state, w_next;
  muldiv_op_t        r_op, w_op;
  logic              r_word, r_a_neg, r_b_neg, r_fast;
  logic [CW-1:0]     r_count;
  logic [XLEN-1:0]   r_result;
  logic [2*XLEN-1:0] r_acc, r_mcand;
  logic [XLEN-1:0]   r_mplier;

  logic            w_accept, w_word, w_a_sgn, w_b_sgn, w_a_neg, w_b_neg;
  logic            w_div0, w_ovf, w_fast, w_last;
  logic [XLEN-1:0] w_a_ext, w_b_ext, w_a_mag, w_b_mag, w_a_sx, w_fast_res;
  logic [XLEN-1:0] w_dq, w_dr, w_quot, w_rem, w_div_res, w_final;

  // Apply the product sign, pick low or high half, and sign-extend word results
  function automatic logic [XLEN-1:0] mul_finalize(input logic [2*XLEN-1:0] mag, input logic neg,
                                                   input logic [1:0] f, input logic word);
    logic [2*XLEN-1:0] p;
    logic [31:0]       p32;
    p = neg ? -mag : mag;
    if (word) begin
      p32 = (f == 2'b00) ? p[31:0] : p[63:32];
      return XLEN'($signed(p32));
    end
    if (f == 2'b00) return p[XLEN-1:0];
    return p[2*XLEN-1:XLEN];
  endfunction

  assign w_accept = in_valid && in_ready;
  assign w_last   = (r_count == (r_word ? CW'(31) : CW'(XLEN - 1)));

  // Extend operands to operation width, split sign/magnitude, detect divide fast-path cases
  always_comb begin
    w_op    = muldiv_op_t'(op);
    w_word  = (W_EN != 0) && is_word;
    w_a_sgn = op_a_signed(w_op);
    w_b_sgn = op_b_signed(w_op);
    w_a_sx  = XLEN'($signed(a[31:0]));
    if (w_word) begin
      w_a_ext = w_a_sgn ? w_a_sx : XLEN'(a[31:0]);
      w_b_ext = w_b_sgn ? XLEN'($signed(b[31:0])) : XLEN'(b[31:0]);
    end else begin
      w_a_ext = a;
      w_b_ext = b;
    end
    w_a_neg = w_a_sgn && w_a_ext[XLEN-1];
    w_b_neg = w_b_sgn && w_b_ext[XLEN-1];
    w_a_mag = w_a_neg ? -w_a_ext : w_a_ext;
    w_b_mag = w_b_neg ? -w_b_ext : w_b_ext;
    w_div0  = (w_b_ext == '0);
    w_ovf   = w_op[2] && w_a_sgn &&
              (w_word ? ((a[31:0] == 32'h8000_0000) && (b[31:0] == 32'hFFFF_FFFF))
                      : ((a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1)));
    w_fast  = w_op[2] && (w_div0 || w_ovf);
    if (w_div0) w_fast_res = w_op[1] ? (w_word ? w_a_sx : a) : '1;
    else        w_fast_res = w_op[1] ? '0 : (w_word ? w_a_sx : a);
`ifdef MUL_DIV_FAST_MUL_EN
    if (!w_op[2]) begin
      w_fast     = 1'b1;
      w_fast_res = mul_finalize({{XLEN{1'b0}}, w_a_mag} * {{XLEN{1'b0}}, w_b_mag},
                                w_a_neg ^ w_b_neg, w_op[1:0], w_word);
    end
`endif
  end

  div_restoring #(.XLEN(XLEN)) u_div (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_accept),
    .i_step    ((r_state == BUSY) && r_op[2]),
    .i_word    (w_word),
    .i_dividend(w_a_mag),
    .i_divisor (w_b_mag),
    .o_quot    (w_dq),
    .o_rem     (w_dr)
  );

  // Restore signs on the iterative results and select the requested value
  always_comb begin
    w_quot    = (r_a_neg ^ r_b_neg) ? -w_dq : w_dq;
    w_rem     = r_a_neg ? -w_dr : w_dr;
    w_div_res = r_op[1] ? w_rem : w_quot;
    if (r_word) w_div_res = XLEN'($signed(w_div_res[31:0]));
    w_final   = r_op[2] ? w_div_res : mul_finalize(r_acc, r_a_neg ^ r_b_neg, r_op[1:0], r_word);
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next state: flush always returns to IDLE, overriding request and response handshakes
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = w_fast ? DONE : BUSY;
      BUSY:    if (w_last) w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (flush) w_next = IDLE;
  end

  // Outputs: result is only driven while DONE, zero otherwise
  always_comb begin
    in_ready  = (r_state == IDLE) && !flush;
    out_valid = (r_state == DONE);
    result    = '0;
    if (r_state == DONE) result = r_fast ? r_result : w_final;
  end

  // Latch the request on acceptance; shift-add one multiplier bit per BUSY cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op     <= OP_MUL;
      r_word   <= 1'b0;
      r_a_neg  <= 1'b0;
      r_b_neg  <= 1'b0;
      r_fast   <= 1'b0;
      r_result <= '0;
      r_count  <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else if (w_accept) begin
      r_op     <= w_op;
      r_word   <= w_word;
      r_a_neg  <= w_a_neg;
      r_b_neg  <= w_b_neg;
      r_fast   <= w_fast;
      r_result <= w_fast_res;
      r_count  <= '0;
      r_acc    <= '0;
      r_mcand  <= {{XLEN{1'b0}}, w_a_mag};
      r_mplier <= w_b_mag;
    end else if (r_state == BUSY) begin
      r_count <= r_count + 1'b1;
      if (!r_op[2]) begin
        if (r_mplier[0]) r_acc <= r_acc + r_mcand;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
      end
    end
  end

endmodule
